// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default frame geometry and one-hot receiver state encoding.
// Used by uart_rx and the companion transmitter.
package uart_rx_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver bus: tick/serial-line inputs and received-word outputs.
// The master modport drives the line; the slave modport is the receiver.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic                 i_tick;
  logic                 i_rx_data;
  logic [DATA_BITS-1:0] o_data_byte;
  logic                 o_done_bit;
  logic                 o_frame_error;
  logic                 o_parity_error;

  modport master (
    output i_tick, i_rx_data,
    input  o_data_byte, o_done_bit, o_frame_error, o_parity_error
  );

  modport slave (
    input  i_tick, i_rx_data,
    output o_data_byte, o_done_bit, o_frame_error, o_parity_error
  );

endinterface

// File: rtl/uart_sync2ff.sv
// Two-flop synchronizer for the asynchronous serial line; 2-clock latency, no backpressure.
// Resets to 1 so a reset never looks like a start bit.
module uart_sync2ff (
  input  logic i_clock,
  input  logic i_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver; done pulses one clock after the stop-bit sample, no backpressure.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic      i_clock,
  input  logic      i_reset,
  uart_rx_if.slave  rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [IW-1:0]        idx, idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 finish;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 ferr_q;

  uart_sync2ff u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .d       (rx.i_rx_data),
    .q       (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_next;
  logic perr_q;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    finish     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next   = par_q;
`endif
    if (rx.i_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_next   = '0;
            state_next = ST_START;
          end
        end
        ST_START: begin
          // Mid start bit: a high line here means the falling edge was a glitch.
          if (cnt == CNT_MID) begin
            cnt_next   = '0;
            state_next = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            shift_next = {rx_s, shift[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              idx_next = '0;
`ifdef UART_RX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            par_next   = rx_s;
            state_next = ST_STOP;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            finish     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
    end
  end

  // Outputs load on the stop-sample edge and hold until the next completed frame.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        data_q <= shift;
        ferr_q <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q <= par_next;
      if (finish) begin
        perr_q <= ^{shift, par_q};
      end
    end
  end

  assign rx.o_parity_error = perr_q;
`else
  assign rx.o_parity_error = 1'b0;
`endif

  assign rx.o_data_byte   = data_q;
  assign rx.o_done_bit    = done_q;
  assign rx.o_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: frames are driven bit-by-bit and results compared
// against expectations derived from the frame contents (data, stop level, parity bit).
module tb_uart_rx;

  localparam int CLKS_PER_BIT = 64;  // tick every 4 clocks, 16 ticks per bit

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   tick_en = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .rx      (bus)
  );

  initial begin
    bus.i_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.i_tick = tick_en;
      @(negedge clk);
      bus.i_tick = 1'b0;
    end
  end

  // Observed completions and protocol anomalies collected by the monitor.
  logic [7:0] obs_d[$];
  logic       obs_fe[$];
  logic       obs_pe[$];
  int         bad_width = 0;
  int         bad_change = 0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_done_bit) begin
        obs_d.push_back(bus.o_data_byte);
        obs_fe.push_back(bus.o_frame_error);
        obs_pe.push_back(bus.o_parity_error);
      end
      if (bus.o_done_bit && prev_done) bad_width++;
      if (bus.o_data_byte !== prev_data && !bus.o_done_bit) bad_change++;
    end
    prev_done = bus.o_done_bit;
    prev_data = bus.o_data_byte;
  end

  // Expected completions.
  logic [7:0] exp_d[$];
  logic       exp_fe[$];
  logic       exp_pe[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.i_rx_data = v;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.i_rx_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Send a full frame; when expect_done, record what a correct receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input bit expect_done);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
    bus.i_rx_data = 1'b1;
    if (expect_done) begin
      exp_d.push_back(d);
      exp_fe.push_back(!stop);
`ifdef UART_RX_PARITY_EN
      exp_pe.push_back((^d) ^ par);
`else
      exp_pe.push_back(1'b0 & par);
`endif
    end
  endtask

  task automatic check_frames(input string tag);
    int n;
    repeat (200) @(negedge clk);
    check({tag, "_count"}, obs_d.size(), exp_d.size());
    n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, obs_d[i], exp_d[i]);
      check({tag, "_ferr"}, obs_fe[i], exp_fe[i]);
      check({tag, "_perr"}, obs_pe[i], exp_pe[i]);
    end
    check({tag, "_pulse_width"}, bad_width, 0);
    check({tag, "_data_stable"}, bad_change, 0);
    obs_d.delete(); obs_fe.delete(); obs_pe.delete();
    exp_d.delete(); exp_fe.delete(); exp_pe.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;

    bus.i_rx_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", bus.o_data_byte, 8'h00);
    check("reset_done", bus.o_done_bit, 1'b0);
    check("reset_ferr", bus.o_frame_error, 1'b0);
    check("reset_perr", bus.o_parity_error, 1'b0);
    rst_n = 1'b1;
    idle(100);

    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
    check_frames("a5");

    // Short low glitch: rejected at the mid-start check.
    bus.i_rx_data = 1'b0;
    repeat (12) @(negedge clk);
    idle(20);
    check_frames("glitch");

    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b1);
    idle(128);
    check_frames("ferr");
    check("ferr_hold", bus.o_frame_error, 1'b1);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b1);
    check_frames("ferr_clear");
    check("ferr_cleared", bus.o_frame_error, 1'b0);

    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    check_frames("b2b");

    // Reset in the middle of 0x55, after data bit 3.
    d = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_data", bus.o_data_byte, 8'h00);
    check("midreset_done", bus.o_done_bit, 1'b0);
    bus.i_rx_data = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(100);
    send_frame(8'h81, 1'b1, ^8'h81, 1'b1);
    check_frames("after_reset");

    // With ticks withheld the receiver stays frozen in idle.
    tick_en = 1'b0;
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
    tick_en = 1'b1;
    idle(100);
    check_frames("freeze");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check_frames("parity");
`endif

    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop, par, 1'b1);
      idle(stop ? $urandom_range(0, 20) : 128);
    end
    check_frames("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
